// File: rtl/inst_fetch_mem_pkg.sv
// Shared constants for the instruction fetch memory: datapath width,
// default NOP encoding and FSM state encodings.
package inst_fetch_mem_pkg;

    localparam int          CPU_WIDTH   = 32;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
    localparam int          WAIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ram.sv
// Instruction storage: one synchronous write port and one asynchronous read
// port, so a read in the same cycle as a write to that word sees the old data.
module inst_fetch_ram #(
    parameter int CPU_WIDTH = 32,
    parameter int DEPTH     = 1024,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [CPU_WIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [CPU_WIDTH-1:0] rdata
);

    // No reset on the array: contents are undefined until the loader writes them.
    logic [CPU_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: request/response handshake with optional wait
// states, error detection for misaligned/out-of-range fetches, and a loader port.
module inst_fetch_mem #(
    parameter int                               CPU_WIDTH   = inst_fetch_mem_pkg::CPU_WIDTH,
    parameter int                               DEPTH       = 1024,
    parameter int                               WAIT_CYCLES = 0,
    parameter logic [CPU_WIDTH-1:0]             NOP_INST    = CPU_WIDTH'(inst_fetch_mem_pkg::NOP_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CPU_WIDTH-1:0] req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CPU_WIDTH-1:0] rsp_inst,
    output logic                 rsp_err,
    input  logic                 flush,
    input  logic                 ld_en,
    input  logic [CPU_WIDTH-1:0] ld_addr,
    input  logic [CPU_WIDTH-1:0] ld_data
);
    import inst_fetch_mem_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    fetch_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CPU_WIDTH-1:0]   rsp_inst_q, rsp_inst_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [CPU_WIDTH-1:0]   rd_data;
    logic                   req_bad;
    logic                   ld_ok;

    // Anything above the word-index field makes the address out of range.
    assign req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != '0);
    assign ld_ok   = ld_en && (ld_addr[1:0] == 2'b00) && ((ld_addr >> (AW + 2)) == '0);

    inst_fetch_ram #(
        .CPU_WIDTH (CPU_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ld_ok),
        .waddr (ld_addr[AW+1:2]),
        .wdata (ld_data),
        .raddr (req_addr[AW+1:2]),
        .rdata (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    rsp_inst_d = req_bad ? NOP_INST : rd_data;
                    rsp_err_d  = req_bad;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // Flush wins over a same-cycle handshake; both simply return to IDLE.
                if (flush || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rsp_inst_q <= NOP_INST;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_inst = rsp_inst_q;
    assign rsp_err  = rsp_err_q;

endmodule
